// File: rtl/shift_arb_pkg.sv
// Shared types and constants for the shift arbiter and its shift core.
// The round-robin build is selected with SHIFT_ARB_RR_EN (see shift_arbiter.sv).
package shift_arb_pkg;

    localparam int DATA_W = 32;
    localparam int AMT_W  = 5;
    localparam int ID_W   = 2;

    localparam logic OP_SLL = 1'b0;
    localparam logic OP_SRA = 1'b1;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [DATA_W-1:0] data;
    } resp_t;

    // Next search start after granting requester g among n requesters.
    function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] g, input int n);
        int nxt;
        nxt = int'(g) + 1;
        if (nxt >= n)
            nxt = 0;
        return ID_W'(nxt);
    endfunction

endpackage

// File: rtl/shift_core.sv
// Combinational 32-bit barrel shifter: logical left or arithmetic right,
// built as log2 stages so each amount bit moves the word by a power of two.
module shift_core
    import shift_arb_pkg::*;
(
    input  logic [DATA_W-1:0] A,
    input  logic [AMT_W-1:0]  shiftamt,
    input  logic              op,
    output logic [DATA_W-1:0] result
);

    logic [DATA_W-1:0]        sll_stg [AMT_W+1];
    logic signed [DATA_W-1:0] sra_stg [AMT_W+1];

    assign sll_stg[0] = A;
    assign sra_stg[0] = $signed(A);

    for (genvar k = 0; k < AMT_W; k++) begin : g_stage
        localparam int SH = 1 << k;
        assign sll_stg[k+1] = shiftamt[k] ? {sll_stg[k][DATA_W-SH-1:0], {SH{1'b0}}} : sll_stg[k];
        // Signed operand makes >>> replicate bit 31 into the vacated positions.
        assign sra_stg[k+1] = shiftamt[k] ? (sra_stg[k] >>> SH) : sra_stg[k];
    end

    assign result = (op == OP_SRA) ? DATA_W'(sra_stg[AMT_W]) : sll_stg[AMT_W];

endmodule

// File: rtl/shift_arbiter.sv
// Arbitrates NREQ requesters onto one shift core with a one-entry response register.
// Define SHIFT_ARB_RR_EN for rotating-pointer round-robin; otherwise lowest index wins.
module shift_arbiter
    import shift_arb_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [DATA_W*NREQ-1:0]  req_a,
    input  logic [AMT_W*NREQ-1:0]   req_amt,
    input  logic [NREQ-1:0]         req_op,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [ID_W-1:0]         resp_id,
    output logic [DATA_W-1:0]       resp_data
);

    logic              vld_p1;
    logic [ID_W-1:0]   id_p1;
    logic [DATA_W-1:0] data_p1;

    logic              stage_free;
    logic              grant_any;
    logic [ID_W-1:0]   grant_idx;
    logic              grant_fire;

    logic [DATA_W-1:0] sel_a;
    logic [AMT_W-1:0]  sel_amt;
    logic              sel_op;
    logic [DATA_W-1:0] shift_res;

    assign stage_free = !vld_p1 || resp_ready;

`ifdef SHIFT_ARB_RR_EN
    logic [ID_W-1:0] ptr;

    // Search starts at ptr and wraps, so the last winner drops to lowest priority.
    always_comb begin
        int cand;
        grant_any = 1'b0;
        grant_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = int'(ptr) + k;
            if (cand >= NREQ)
                cand = cand - NREQ;
            if (!grant_any && req_valid[cand]) begin
                grant_any = 1'b1;
                grant_idx = ID_W'(cand);
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            ptr <= '0;
        else if (grant_fire)
            ptr <= wrap_inc(grant_idx, NREQ);
    end
`else
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!grant_any && req_valid[k]) begin
                grant_any = 1'b1;
                grant_idx = ID_W'(k);
            end
        end
    end
`endif

    assign grant_fire = stage_free && grant_any;

    // Gated by reset_n so no requester sees a handshake while the block is held in reset.
    always_comb begin
        req_ready = '0;
        if (reset_n && grant_fire)
            req_ready = NREQ'(1) << grant_idx;
    end

    // Operand mux feeds only the datapath; the grant never looks at operands.
    always_comb begin
        sel_a   = '0;
        sel_amt = '0;
        sel_op  = OP_SLL;
        for (int k = 0; k < NREQ; k++) begin
            if (grant_idx == ID_W'(k)) begin
                sel_a   = req_a[k*DATA_W +: DATA_W];
                sel_amt = req_amt[k*AMT_W +: AMT_W];
                sel_op  = req_op[k];
            end
        end
    end

    shift_core u_core (
        .A        (sel_a),
        .shiftamt (sel_amt),
        .op       (sel_op),
        .result   (shift_res)
    );

    // ---- p0 -> p1: response register ----
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            vld_p1  <= 1'b0;
            id_p1   <= '0;
            data_p1 <= '0;
        end else if (stage_free) begin
            vld_p1 <= grant_any;
            if (grant_any) begin
                id_p1   <= grant_idx;
                data_p1 <= shift_res;
            end
        end
    end

    assign resp_valid = vld_p1;
    assign resp_id    = id_p1;
    assign resp_data  = data_p1;

endmodule

// File: doc/shift_arbiter.md
# shift_arbiter

Shares one 32-bit shift core (logical left and arithmetic right) among up to four requesters in the processor (ALU execute path, multiply/divide unit, address-generation logic). Per-requester valid/ready handshake, arbitration on the shared core, and a one-entry registered response stage with backpressure. Sustains one shift per cycle with one-cycle latency.

## Interface
- NREQ, 2, number of requesters; legal range 2–4
- clock  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- req_valid  input  NREQ  request i presents an operation
- req_ready  output  NREQ  request i is accepted this cycle (one-hot or zero)
- req_a  input  32*NREQ  operand for request i, slice [32i+31:32i]
- req_amt  input  5*NREQ  shift amount for request i, slice [5i+4:5i]
- req_op  input  NREQ  0 = sll, 1 = sra
- resp_valid  output  1  response register holds a result
- resp_ready  input  1  consumer takes the response this cycle
- resp_id  output  2  index of the requester that owns the response
- resp_data  output  32  shifted result

## Operation
- Stage free = !resp_valid || resp_ready.
- When the stage is free and any req_valid is high, exactly one requester is granted: req_ready[g] = 1. Otherwise req_ready = 0.
- The grant is purely combinational from req_valid, the stage state and the priority pointer. req_ready must not depend on req_a, req_amt or req_op.
- On a grant, the core computes req_a[g] shifted by req_amt[g] per req_op[g]. Result, g and resp_valid = 1 load at the next edge.
- sll: zero fill from the LSB.
- sra: fill with req_a[g][31].
- Amount is 0–31 with no wrap. Amount 0 returns the operand unchanged.
- If the stage is free and there is no grant, resp_valid clears at the edge. resp_data and resp_id hold their last values.
- While resp_valid = 1 and resp_ready = 0, resp_data, resp_id and resp_valid hold stable.
- Priority pointer ptr (0..NREQ-1): the search starts at ptr and wraps modulo NREQ. After a grant to g, ptr becomes (g+1) mod NREQ. ptr is unchanged on cycles with no grant.
- Requesters may drop req_valid without being granted; the arbiter keeps no memory of pending requests.
- Simultaneous resp_ready and a new grant in the same cycle: the old response retires and the new one loads; there is no bubble.

## Timing
- Reset (async assert, sync release): resp_valid = 0, resp_data = 0, resp_id = 0, ptr = 0. req_ready = 0 while reset_n is low.
- Latency: grant edge to resp_valid is one cycle.
- Throughput: one result per cycle while resp_ready stays high.
- Reset asserted mid-transfer discards the response register contents. No partial state survives.
- Fairness (round-robin build): a continuously valid requester is granted within NREQ grants.

## Configuration
- SHIFT_ARB_RR_EN defined: rotating-pointer round-robin as described above.
- Not defined: fixed priority, lowest index wins. ptr is not implemented, and requester 0 can starve the others.
- All other behaviour is identical in both builds.

## Structure
- Package shift_arb_pkg holds:
  - op encodings OP_SLL = 1'b0, OP_SRA = 1'b1
  - DATA_W = 32, AMT_W = 5
  - requester id width ID_W = 2
- Sub-module shift_core(A, shiftamt, op, result) combines the existing left shifter with an arithmetic-right shifter. It is purely combinational.
- The arbiter itself holds the grant logic, the ptr register and the response register.

## Test plan
1. Single request, round-robin build: req 0 sends sll, A = 0x0000_0001, amt = 31 -> req_ready[0] = 1 in the same cycle; the next cycle gives resp_valid = 1, resp_data = 0x8000_0000, resp_id = 0.
2. sra sign fill: req 1 sends A = 0x8000_0000, amt = 4 -> resp_data = 0xF800_0000. Amt 0 on A = 0x1234_5678 -> 0x1234_5678.
3. Round-robin: NREQ = 3, all valid for 6 cycles with resp_ready = 1 -> grant order 0,1,2,0,1,2 and one response per cycle. Without SHIFT_ARB_RR_EN -> all six grants go to 0.
4. Backpressure: a response is pending and resp_ready = 0 for 3 cycles with req_valid = 2'b11 -> req_ready = 0 and resp_data/resp_id stable. On resp_ready = 1, a grant issues in that same cycle and the new data appears on the next cycle.
5. Reset mid-operation: drop reset_n while resp_valid = 1 -> resp_valid, resp_data and resp_id go to 0 immediately. After release, the first grant goes to requester 0.
